// File: rtl/seg7_reader_if.sv
// Segment/digit scan bus into seg7_reader and the recovered digit codes out of it.
interface seg7_reader_if;
    logic [0:7]  SEG;
    logic [3:0]  DIG;
    logic [11:0] CODE;
    logic [3:0]  VAL;
    logic [3:0]  ERR;
    logic        UPD;

    modport master (output SEG, DIG, input CODE, VAL, ERR, UPD);
    modport slave  (input SEG, DIG, output CODE, VAL, ERR, UPD);
endinterface

// File: rtl/seg7_reader.sv
// Recovers 3-bit digit codes from a multiplexed 7-segment scan after STABLE identical samples.
// Optional macro SEG7_READER_DP_CHECK_EN: a capture is legal only when the dp segment is lit.
module seg7_reader #(
    parameter int unsigned STABLE = 4
) (
    input logic          clk,
    input logic          rst,
    seg7_reader_if.slave bus
);
    localparam logic [7:0] StableCnt = 8'(STABLE);

    logic [0:7]  r_seg;
    logic [3:0]  r_dig;
    logic [7:0]  r_cnt;
    logic [11:0] r_code;
    logic [3:0]  r_val;
    logic [3:0]  r_err;
    logic [3:0]  r_seen;
    logic        r_upd;

    logic       w_onehot;
    logic       w_same;
    logic [7:0] w_cnt_d;
    logic       w_capture;
    logic [6:0] w_seg7;
    logic       w_legal_pat;
    logic       w_legal;
    logic [2:0] w_code;
    logic [3:0] w_seen_nxt;

    assign w_onehot   = (bus.DIG != 4'd0) && ((bus.DIG & (bus.DIG - 4'd1)) == 4'd0);
    assign w_same     = (bus.SEG == r_seg) && (bus.DIG == r_dig);
    assign w_seg7     = bus.SEG[0:6];
    assign w_seen_nxt = r_seen | bus.DIG;

    always_comb begin
        w_cnt_d = r_cnt;
        if (!w_onehot) begin
            w_cnt_d = 8'd0;
        end else if (!w_same) begin
            w_cnt_d = 8'd1;
        end else if (r_cnt < StableCnt) begin
            w_cnt_d = r_cnt + 8'd1;
        end
    end

    // Capture only on the edge the count reaches STABLE; a saturated count never re-captures.
    assign w_capture = w_onehot && (w_cnt_d == StableCnt) && (!w_same || (r_cnt != StableCnt));

    always_comb begin
        w_legal_pat = 1'b1;
        w_code      = 3'd0;
        case (w_seg7)
            7'b1111110: w_code = 3'd0;
            7'b0110000: w_code = 3'd1;
            7'b1101101: w_code = 3'd2;
            7'b1111001: w_code = 3'd3;
            7'b0110011: w_code = 3'd4;
            7'b1011011: w_code = 3'd5;
            7'b1011111: w_code = 3'd6;
            7'b1110000: w_code = 3'd7;
            default:    w_legal_pat = 1'b0;
        endcase
    end

`ifdef SEG7_READER_DP_CHECK_EN
    assign w_legal = w_legal_pat & bus.SEG[7];
`else
    assign w_legal = w_legal_pat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg  <= '0;
            r_dig  <= '0;
            r_cnt  <= '0;
            r_code <= '0;
            r_val  <= '0;
            r_err  <= '0;
            r_seen <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_seg <= bus.SEG;
            r_dig <= bus.DIG;
            r_cnt <= w_cnt_d;
            r_upd <= 1'b0;
            if (w_capture) begin
                for (int d = 0; d < 4; d++) begin
                    if (bus.DIG[d]) begin
                        r_code[3*d +: 3] <= w_legal ? w_code : 3'd0;
                        r_val[d]         <= 1'b1;
                        r_err[d]         <= !w_legal;
                    end
                end
                if (w_seen_nxt == 4'hF) begin
                    r_upd  <= 1'b1;
                    r_seen <= 4'd0;
                end else begin
                    r_seen <= w_seen_nxt;
                end
            end
        end
    end

    assign bus.CODE = r_code;
    assign bus.VAL  = r_val;
    assign bus.ERR  = r_err;
    assign bus.UPD  = r_upd;
endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: vector table with scoreboard plus reset/DP/jitter sequences.
module tb_seg7_reader;
    localparam int unsigned Stable = 4;

    typedef struct {
        logic [3:0]  dig;
        logic [0:7]  seg;
        logic [11:0] code;
        logic [3:0]  val;
        logic [3:0]  err;
        logic        upd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t exp_q[$];

    seg7_reader_if bus ();

    seg7_reader #(.STABLE(Stable)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [0:7] pat(input int unsigned v, input logic dp);
        logic [6:0] p;
        case (v)
            0:       p = 7'b1111110;
            1:       p = 7'b0110000;
            2:       p = 7'b1101101;
            3:       p = 7'b1111001;
            4:       p = 7'b0110011;
            5:       p = 7'b1011011;
            6:       p = 7'b1011111;
            7:       p = 7'b1110000;
            default: p = 7'b0000001;
        endcase
        return {p, dp};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] d, input logic [0:7] s, input int n);
        bus.DIG = d;
        bus.SEG = s;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.DIG = 4'd0;
        bus.SEG = 8'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        logic [11:0] p_code;
        logic [3:0]  p_val, p_err;
        logic        dp_err;

        bus.DIG = 4'd0;
        bus.SEG = 8'd0;
        #1 rst = 1'b1;
        #2;
        chk("reset_code", 32'(bus.CODE), 32'h0);
        chk("reset_flags", 32'({bus.VAL, bus.ERR, bus.UPD}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Digits 0..3 end up as 7,0,5,3 after an illegal capture and two overwrites.
        vecs[0] = '{4'b0100, pat(2, 1'b1), 12'h080, 4'b0100, 4'b0000, 1'b0};
        vecs[1] = '{4'b0001, pat(7, 1'b1), 12'h087, 4'b0101, 4'b0000, 1'b0};
        vecs[2] = '{4'b0010, pat(9, 1'b1), 12'h087, 4'b0111, 4'b0010, 1'b0};
        vecs[3] = '{4'b0100, pat(5, 1'b1), 12'h147, 4'b0111, 4'b0010, 1'b0};
        vecs[4] = '{4'b0010, pat(0, 1'b1), 12'h147, 4'b0111, 4'b0000, 1'b0};
        vecs[5] = '{4'b1000, pat(3, 1'b1), 12'h747, 4'b1111, 4'b0000, 1'b1};

        p_code = 12'h0;
        p_val  = 4'h0;
        p_err  = 4'h0;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i]);
            hold(vecs[i].dig, vecs[i].seg, Stable - 1);
            chk($sformatf("v%0d_early", i), 32'({bus.CODE, bus.VAL, bus.ERR}),
                32'({p_code, p_val, p_err}));
            tick();
            v = exp_q.pop_front();
            chk($sformatf("v%0d_code", i), 32'(bus.CODE), 32'(v.code));
            chk($sformatf("v%0d_val", i), 32'(bus.VAL), 32'(v.val));
            chk($sformatf("v%0d_err", i), 32'(bus.ERR), 32'(v.err));
            chk($sformatf("v%0d_upd", i), 32'(bus.UPD), 32'(v.upd));
            tick();
            chk($sformatf("v%0d_hold", i), 32'({bus.CODE, bus.VAL, bus.ERR, bus.UPD}),
                32'({v.code, v.val, v.err, 1'b0}));
            p_code = v.code;
            p_val  = v.val;
            p_err  = v.err;
        end

        // SEG toggling every 3 cycles never reaches the stable count.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            hold(4'b0001, pat((k % 2 == 0) ? 1 : 4, 1'b1), 3);
            chk($sformatf("jitter_val%0d", k), 32'(bus.VAL), 32'h0);
        end

        // Multi-hot then zero DIG: no capture, no UPD; next valid sample restarts at count 1.
        hold(4'b0011, pat(2, 1'b1), 10);
        chk("multihot_flags", 32'({bus.VAL, bus.UPD}), 32'h0);
        hold(4'b0000, pat(2, 1'b1), 3);
        chk("zerodig_flags", 32'({bus.VAL, bus.UPD}), 32'h0);
        hold(4'b0001, pat(1, 1'b1), Stable - 1);
        chk("restart_early", 32'(bus.VAL), 32'h0);
        tick();
        chk("restart_val", 32'(bus.VAL), 32'h1);
        chk("restart_code", 32'(bus.CODE), 32'h1);

        // A toggling dp still counts as a changed sample; a held dp=0 is judged by the DP check.
        for (int k = 0; k < 4; k++) begin
            hold(4'b0010, pat(1, k[0]), 2);
        end
        chk("dp_toggle_val", 32'(bus.VAL), 32'h1);
        hold(4'b0010, pat(1, 1'b0), Stable);
`ifdef SEG7_READER_DP_CHECK_EN
        dp_err = 1'b1;
`else
        dp_err = 1'b0;
`endif
        chk("dp_val", 32'(bus.VAL), 32'h3);
        chk("dp_err", 32'(bus.ERR[1]), 32'(dp_err));
        chk("dp_code", 32'(bus.CODE[5:3]), dp_err ? 32'd0 : 32'd1);

        // Reset mid-frame discards the seen mask.
        do_reset();
        hold(4'b0001, pat(7, 1'b1), Stable);
        hold(4'b0010, pat(0, 1'b1), Stable);
        hold(4'b0100, pat(5, 1'b1), Stable);
        chk("pre_rst_val", 32'(bus.VAL), 32'h7);
        #2 rst = 1'b1;
        bus.DIG = 4'd0;
        #1;
        chk("async_rst_out", 32'({bus.CODE, bus.VAL, bus.ERR, bus.UPD}), 32'h0);
        #4 rst = 1'b0;
        hold(4'b1000, pat(3, 1'b1), Stable);
        chk("post_rst_val", 32'(bus.VAL), 32'h8);
        chk("post_rst_upd0", 32'(bus.UPD), 32'h0);
        tick();
        chk("post_rst_upd1", 32'(bus.UPD), 32'h0);
        hold(4'b0001, pat(7, 1'b1), Stable);
        hold(4'b0010, pat(0, 1'b1), Stable);
        chk("frame_upd_early", 32'(bus.UPD), 32'h0);
        hold(4'b0100, pat(5, 1'b1), Stable);
        chk("frame_upd", 32'(bus.UPD), 32'h1);
        chk("frame_code", 32'(bus.CODE), 32'h747);
        tick();
        chk("frame_upd_drop", 32'(bus.UPD), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter: STABLE, 4, consecutive identical samples required before capture (range 1..255).
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 SEG  input  [0:7]  active-high segment bus; SEG[0..6]=a..g, SEG[7]=dp.
REQ-005 DIG  input  4  active-high digit strobe, one-hot when valid; DIG[d] selects digit d.
REQ-006 CODE  output  12  recovered 3-bit codes; digit d at CODE[3d+2:3d].
REQ-007 VAL  output  4  VAL[d]=1: digit d captured at least once since reset.
REQ-008 ERR  output  4  ERR[d]=1: last capture of digit d was not a legal pattern.
REQ-009 UPD  output  1  one-cycle pulse: all four digits captured since the last pulse.

Function
REQ-010 The block SHALL register SEG and DIG into a sample stage on every rising edge.
REQ-011 Legal patterns (SEG[0..6]) SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
REQ-012 An 8-bit counter SHALL:
- load 1 when the new sample differs from the held sample;
- increment, saturating at STABLE, when the samples are equal;
- load 0 when the sampled DIG is not one-hot (zero or multiple bits set).
REQ-013 On the edge where the counter becomes STABLE with a one-hot DIG, digit d SHALL be captured:
- CODE[d] <= encoded value;
- VAL[d] <= 1;
- ERR[d] <= 1 if the pattern is illegal, else 0;
- CODE[d] <= 0 when illegal.
REQ-014 Capture latency SHALL be exactly STABLE edges, counting the first edge that samples the new input value; STABLE=1 captures on that first edge.
REQ-015 A held, unchanged input SHALL produce exactly one capture, with no re-capture while the counter stays saturated.
REQ-016 A 4-bit seen mask SHALL set bit d on each capture of digit d.
REQ-017 When a capture makes the seen mask 1111, UPD SHALL be 1 for the following cycle only, and the mask SHALL clear on that same edge.
REQ-018 Re-capturing a digit before the mask completes SHALL overwrite CODE/ERR for that digit and leave the mask unchanged.
REQ-019 A non-one-hot DIG interrupting a stable run SHALL restart qualification from the counter loading 1 on the next valid changed sample.
REQ-020 CODE/VAL/ERR SHALL otherwise hold their values indefinitely.

Reset
REQ-021 Asserting rst SHALL immediately clear CODE, VAL, ERR, UPD, the counter, the sample stage and the seen mask, regardless of clock.
REQ-022 A reset arriving mid-qualification or mid-frame SHALL discard all partial progress; no UPD pulse follows deassertion until four fresh captures occur.
REQ-023 The first rising edge after rst deasserts SHALL be treated as sampling a new value (counter loads 1 if DIG is one-hot).

Configuration
REQ-024 Macro SEG7_READER_DP_CHECK_EN defined: a pattern SHALL be legal only if SEG[7]=1 and SEG[0..6] matches REQ-011; SEG[7]=0 SHALL set ERR[d].
REQ-025 Macro SEG7_READER_DP_CHECK_EN undefined: SEG[7] SHALL be ignored for legality, but it still participates in the sample-equality comparison.

Verification
REQ-026 STABLE=4, DIG=0100, SEG[0..6]=1101101 held from edge 1 -> CODE[8:6]=2, VAL=0100, ERR=0000 after edge 4; no change at edge 5+.
REQ-027 STABLE=4, DIG=0001 held with SEG toggling every 3 cycles -> no capture; VAL stays 0000.
REQ-028 Capture digits 0..3 with patterns for 7,0,5,3 in sequence -> CODE=12'b011_101_000_111; UPD high exactly one cycle after the digit-3 capture; the mask then clears.
REQ-029 DIG=0011 held 10 cycles, then DIG=0000 -> no capture and no UPD; counter remains 0.
REQ-030 Illegal SEG[0..6]=0000001 on digit 1 -> ERR=0010, CODE[5:3]=0, VAL[1]=1; with DP_CHECK_EN, a legal 1 pattern plus SEG[7]=0 -> ERR[1]=1.
REQ-031 rst pulsed for half a cycle after three of four digits are captured -> all outputs 0 immediately; one later digit-3 capture yields no UPD.
